// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared register-file geometry used by the writeback stage
package wb_arbiter_pkg;
    localparam int LEN_REG     = 32;
    localparam int N_REG       = 16;
    localparam int LEN_REG_IDX = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, scanning from ptr upward with wrap
module rr_arbiter #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    logic [N-1:0] rot;
    logic [N-1:0] first;
    // rotate so ptr sits at bit 0, keep the lowest request, rotate back
    always_comb begin
        rot   = N'({req, req} >> ptr);
        first = rot & (-rot);
        gnt   = N'(({first, first} << ptr) >> N);
        idx   = '0;
        for (int i = 0; i < N; i++)
            idx = gnt[i] ? W'(i) : idx;
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter driving register-file cells (optional WB_ARBITER_PERF_EN stall counter)
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int P_LEN_REG     = LEN_REG,
    parameter int P_N_REG       = N_REG,
    parameter int P_LEN_REG_IDX = LEN_REG_IDX,
    parameter int N_SRC         = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_SRC-1:0]                 src_valid_i,
    input  logic [N_SRC*P_LEN_REG_IDX-1:0]   src_dst_i,
    input  logic [N_SRC*P_LEN_REG-1:0]       src_data_i,
    output logic [N_SRC-1:0]                 src_ready_o,
    output logic [P_N_REG-1:0]               wb_o,
    output logic [P_LEN_REG-1:0]             wb_data_o,
    output logic                             wb_valid_o,
    output logic [P_LEN_REG_IDX-1:0]         wb_dst_o,
    output logic                             err_o
`ifdef WB_ARBITER_PERF_EN
    ,
    output logic [31:0]                      perf_stall_o
`endif
);
    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [PW-1:0]            ptr;
    logic [PW-1:0]            gnt_idx;
    logic [PW-1:0]            ptr_nxt;
    logic [N_SRC-1:0]         gnt;
    logic                     any;
    logic [P_LEN_REG_IDX-1:0] sel_dst;
    logic [P_LEN_REG-1:0]     sel_data;
    logic [P_N_REG-1:0]       dec;

    rr_arbiter #(.N(N_SRC), .W(PW)) u_rr (
        .req (src_valid_i),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign src_ready_o = rst ? gnt : '0;
    assign any         = |src_ready_o;
    assign ptr_nxt     = (gnt_idx == PW'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;

    // select the granted source's payload and decode its destination
    always_comb begin
        sel_dst  = '0;
        sel_data = '0;
        dec      = '0;
        for (int i = 0; i < N_SRC; i++) begin
            sel_dst  = gnt[i] ? src_dst_i[i*P_LEN_REG_IDX +: P_LEN_REG_IDX] : sel_dst;
            sel_data = gnt[i] ? src_data_i[i*P_LEN_REG +: P_LEN_REG] : sel_data;
        end
        for (int i = 0; i < P_N_REG; i++)
            dec[i] = (sel_dst == P_LEN_REG_IDX'(i));
    end

    // pointer, registered writeback presentation and sticky range error
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr        <= '0;
            wb_o       <= '0;
            wb_data_o  <= '0;
            wb_valid_o <= 1'b0;
            wb_dst_o   <= '0;
            err_o      <= 1'b0;
        end else begin
            wb_valid_o <= any;
            wb_o       <= any ? dec : '0;
            if (any) begin
                ptr       <= ptr_nxt;
                wb_dst_o  <= sel_dst;
                wb_data_o <= sel_data;
            end
            if (any && dec == '0)
                err_o <= 1'b1;
        end
    end

`ifdef WB_ARBITER_PERF_EN
    // saturating count of cycles where some valid source waits
    always_ff @(posedge clk) begin
        if (!rst)
            perf_stall_o <= '0;
        else if ($countones(src_valid_i) >= 2 && perf_stall_o != '1)
            perf_stall_o <= perf_stall_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed table-driven checks of the writeback arbiter
module tb_wb_arbiter;
    localparam logic [31:0] D0 = 32'hDEADBEEF;
    localparam logic [31:0] D1 = 32'h1111_2222;
    localparam logic [31:0] D2 = 32'h3333_4444;

    typedef struct {
        bit        r;
        bit [2:0]  v;
        bit [3:0]  a, b, c;
        bit [2:0]  rdy;
        bit        wv;
        bit [11:0] wb;
        bit [3:0]  wd;
        bit [31:0] wx;
        bit        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  src_valid_i = '0;
    logic [11:0] src_dst_i = '0;
    logic [95:0] src_data_i;
    logic [2:0]  src_ready_o;
    logic [11:0] wb_o;
    logic [31:0] wb_data_o;
    logic        wb_valid_o;
    logic [3:0]  wb_dst_o;
    logic        err_o;
`ifdef WB_ARBITER_PERF_EN
    logic [31:0] perf_stall_o;
`endif

    int checks = 0;
    int passes = 0;
    vec_t tbl[$];

    assign src_data_i = {D2, D1, D0};

    always #5 clk = ~clk;

    wb_arbiter #(.P_N_REG(12), .N_SRC(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid_i (src_valid_i),
        .src_dst_i   (src_dst_i),
        .src_data_i  (src_data_i),
        .src_ready_o (src_ready_o),
        .wb_o        (wb_o),
        .wb_data_o   (wb_data_o),
        .wb_valid_o  (wb_valid_o),
        .wb_dst_o    (wb_dst_o),
        .err_o       (err_o)
`ifdef WB_ARBITER_PERF_EN
        ,
        .perf_stall_o(perf_stall_o)
`endif
    );

    task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s[%0d]: got %h, expected %h", name, n, act, exp);
    endtask

    function automatic vec_t mk(bit r, bit [2:0] v, bit [3:0] a, bit [3:0] b, bit [3:0] c, bit [2:0] rdy,
                                bit wv, bit [11:0] wb, bit [3:0] wd, bit [31:0] wx, bit err);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.b = b; t.c = c; t.rdy = rdy;
        t.wv = wv; t.wb = wb; t.wd = wd; t.wx = wx; t.err = err;
        return t;
    endfunction

    initial begin
        logic [2:0] rr_rdy [3];
        logic [11:0] rr_wb [3];
        rr_rdy = '{3'b001, 3'b010, 3'b100};
        rr_wb  = '{12'h002, 12'h004, 12'h008};
        //                r  v       a  b  c  rdy     wv wb       wd    wx  err
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 12'h000, 0,    0,  0));
        tbl.push_back(mk(0, 3'b111, 1, 2, 3, 3'b000, 0, 12'h000, 0,    0,  0));
        tbl.push_back(mk(1, 3'b000, 0, 0, 0, 3'b000, 0, 12'h000, 0,    0,  0));
        tbl.push_back(mk(1, 3'b001, 5, 0, 0, 3'b001, 1, 12'h020, 5,    D0, 0));
        tbl.push_back(mk(1, 3'b000, 0, 0, 0, 3'b000, 0, 12'h000, 5,    D0, 0));
        tbl.push_back(mk(1, 3'b111, 1, 2, 3, 3'b010, 1, 12'h004, 2,    D1, 0));
        tbl.push_back(mk(1, 3'b111, 1, 2, 3, 3'b100, 1, 12'h008, 3,    D2, 0));
        tbl.push_back(mk(1, 3'b111, 1, 2, 3, 3'b001, 1, 12'h002, 1,    D0, 0));
        tbl.push_back(mk(1, 3'b111, 1, 2, 3, 3'b010, 1, 12'h004, 2,    D1, 0));
        tbl.push_back(mk(1, 3'b111, 1, 2, 3, 3'b100, 1, 12'h008, 3,    D2, 0));
        tbl.push_back(mk(1, 3'b111, 1, 2, 3, 3'b001, 1, 12'h002, 1,    D0, 0));
        tbl.push_back(mk(1, 3'b100, 0, 0, 7, 3'b100, 1, 12'h080, 7,    D2, 0));
        tbl.push_back(mk(1, 3'b011, 4, 6, 0, 3'b001, 1, 12'h010, 4,    D0, 0));
        tbl.push_back(mk(1, 3'b010, 0, 6, 0, 3'b010, 1, 12'h040, 6,    D1, 0));
        tbl.push_back(mk(1, 3'b011, 8, 9, 0, 3'b001, 1, 12'h100, 8,    D0, 0));
        tbl.push_back(mk(1, 3'b010, 0, 9, 0, 3'b010, 1, 12'h200, 9,    D1, 0));
        tbl.push_back(mk(1, 3'b100, 0, 0, 9, 3'b100, 1, 12'h200, 9,    D2, 0));
        tbl.push_back(mk(1, 3'b010, 0, 15,0, 3'b010, 1, 12'h000, 15,   D1, 1));
        tbl.push_back(mk(1, 3'b000, 0, 0, 0, 3'b000, 0, 12'h000, 15,   D1, 1));
        tbl.push_back(mk(1, 3'b001, 12,0, 0, 3'b001, 1, 12'h000, 12,   D0, 1));
        tbl.push_back(mk(1, 3'b100, 0, 0, 11,3'b100, 1, 12'h800, 11,   D2, 1));
        tbl.push_back(mk(1, 3'b001, 10,0, 0, 3'b001, 1, 12'h400, 10,   D0, 1));
        tbl.push_back(mk(0, 3'b001, 3, 0, 0, 3'b000, 0, 12'h000, 0,    0,  0));
        tbl.push_back(mk(1, 3'b111, 1, 2, 3, 3'b001, 1, 12'h002, 1,    D0, 0));
        tbl.push_back(mk(1, 3'b111, 1, 2, 3, 3'b010, 1, 12'h004, 2,    D1, 0));
        for (int n = 0; n < tbl.size(); n++) begin
            @(negedge clk);
            rst = tbl[n].r;
            src_valid_i = tbl[n].v;
            src_dst_i = {tbl[n].c, tbl[n].b, tbl[n].a};
            #1;
            chk("ready", n, 32'(src_ready_o), 32'(tbl[n].rdy));
            @(posedge clk);
            #1;
            chk("wb_valid", n, 32'(wb_valid_o), 32'(tbl[n].wv));
            chk("wb", n, 32'(wb_o), 32'(tbl[n].wb));
            chk("wb_dst", n, 32'(wb_dst_o), 32'(tbl[n].wd));
            chk("wb_data", n, wb_data_o, tbl[n].wx);
            chk("err", n, 32'(err_o), 32'(tbl[n].err));
        end
        @(negedge clk);
        rst = 1'b0;
        src_valid_i = 3'b000;
        @(posedge clk);
        #1;
`ifdef WB_ARBITER_PERF_EN
        chk("perf_reset", 0, perf_stall_o, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        src_valid_i = 3'b111;
        src_dst_i = {4'd3, 4'd2, 4'd1};
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("rr_ready", k, 32'(src_ready_o), 32'(rr_rdy[k % 3]));
            @(posedge clk);
            #1;
            chk("rr_wb_valid", k, 32'(wb_valid_o), 1);
            chk("rr_wb", k, 32'(wb_o), 32'(rr_wb[k % 3]));
`ifdef WB_ARBITER_PERF_EN
            chk("perf", k, perf_stall_o, 32'(k + 1));
`endif
            @(negedge clk);
        end
        src_valid_i = 3'b000;
        @(posedge clk);
        #1;
        chk("drain_wb_valid", 0, 32'(wb_valid_o), 0);
        chk("drain_wb", 0, 32'(wb_o), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file's cells.
- Collects results from N_SRC producers (ALU, load unit, etc.) through valid/ready ports.
- Grants one result per cycle using round-robin.
- Drives each cell's write strobe (wb) and data input from a registered output, so results land in the register file.

Parameters:
- LEN_REG, 32, register data width; taken from the shared insn defs.
- N_REG, 16, number of architectural registers / cells driven.
- LEN_REG_IDX, 4, width of a register index; must satisfy 2**LEN_REG_IDX >= N_REG.
- N_SRC, 3, number of producer ports, 1..8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- src_valid_i  in  N_SRC  per-producer result valid.
- src_dst_i  in  N_SRC*LEN_REG_IDX  per-producer destination index; source i occupies slice i.
- src_data_i  in  N_SRC*LEN_REG  per-producer result data; source i occupies slice i.
- src_ready_o  out  N_SRC  one-hot grant; transfer occurs when valid&ready.
- wb_o  out  N_REG  one-hot write strobe, one bit per cell's wb_i.
- wb_data_o  out  LEN_REG  shared data bus to every cell's data_i.
- wb_valid_o  out  1  a writeback is being presented this cycle.
- wb_dst_o  out  LEN_REG_IDX  index of the register being written.
- err_o  out  1  sticky: a transfer with dst >= N_REG was accepted.

Behaviour:
- Reset (rst low at posedge):
  - wb_o, wb_valid_o, wb_dst_o, wb_data_o, err_o all clear to 0.
  - RR pointer clears to 0.
  - Any transfer accepted in that same cycle is dropped.
- Arbitration (combinational within cycle T):
  - Grant goes to the first i with src_valid_i[i]=1, scanning from ptr upward and wrapping modulo N_SRC.
  - src_ready_o is one-hot at that i, or all-zero if there are no valids.
  - src_ready_o is never asserted for an invalid source.
  - src_ready_o must not depend on src_dst_i or src_data_i.
  - While rst is low, src_ready_o = 0.
- Pointer update on a grant to i: ptr <= (i+1) mod N_SRC. No grant: ptr holds.
- Producer rule: once asserted, valid, dst and data are held stable until ready. The bench checks this; the RTL does not.
- Output latency:
  - A transfer accepted in cycle T is presented in cycle T+1.
  - Presentation means wb_valid_o=1, wb_dst_o=dst, wb_data_o=data, wb_o = one-hot(dst).
  - Exactly one cycle, no backpressure; cells always accept.
- Throughput: one writeback per cycle sustained.
  - Back-to-back grants produce back-to-back strobes.
  - Idle cycles produce wb_valid_o=0 and wb_o=0. wb_data_o/wb_dst_o hold their last value.
- Out-of-range dst (>= N_REG):
  - The transfer is accepted normally.
  - wb_valid_o=1 and wb_dst_o=dst, but wb_o=0 (no cell written).
  - err_o is set and stays set until reset.
- Same dst from two sources in consecutive grants: both writebacks appear in grant order; the last one wins in the cell.
- Single source (N_SRC=1): ready = valid; ptr stays 0.
- Interaction with reservation: the cell gives reserve-set priority over wb-clear. This block issues wb irrespective of reservation state.

Optional Feature:
- Macro WB_ARBITER_PERF_EN.
- When defined:
  - Adds port perf_stall_o, out, 32 bits.
  - Counts cycles in which popcount(src_valid_i) >= 2, i.e. at least one valid source is not granted.
  - Increments by 1 per such cycle, saturates at 0xFFFFFFFF, and clears on reset.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared defs package holds LEN_REG, N_REG and LEN_REG_IDX (already the insn defs include).
- One natural sub-module: rr_arbiter (N parameter; inputs req, ptr; outputs one-hot gnt and gnt index), purely combinational.
- Pointer register, output registers, decode and err flag stay in wb_arbiter.

Test Plan:
1. Reset then idle:
   - Stimulus: hold rst low 2 cycles, then src_valid=0.
   - Required: wb_o=0, wb_valid_o=0, wb_data_o=0, err_o=0, src_ready_o=0.
2. Single transfer:
   - Stimulus: src0 valid, dst=5, data=0xDEADBEEF at cycle T.
   - Required: src_ready_o=3'b001 at T; at T+1 wb_o=16'h0020, wb_data_o=0xDEADBEEF, wb_valid_o=1; at T+2 wb_o=0.
3. Round-robin fairness:
   - Stimulus: all 3 sources valid continuously with dst=1,2,3.
   - Required: grants 0,1,2,0,1,2; wb_o sequence 0x0002, 0x0004, 0x0008 repeating with no bubble; with PERF_EN, perf_stall_o increments every cycle.
4. Pointer wrap with sparse requests:
   - Stimulus: grant src2, next cycle src0 and src1 valid.
   - Required: src0 granted first (ptr wrapped to 0), then src1.
5. Out-of-range dst:
   - Stimulus: src1 valid with dst=4'hF when N_REG=12.
   - Required: ready given; at T+1 wb_valid_o=1, wb_dst_o=15, wb_o=0; err_o=1 and stays set until rst.
6. Reset mid-operation:
   - Stimulus: accept src0 dst=3 at T with rst low at the T posedge.
   - Required: no strobe at T+1; ptr=0, so with all sources valid after release, src0 is granted first.
